// File: rtl/gpio_deb_pkg.sv
// Shared constants and helpers for the multi-channel GPIO debouncer.
package gpio_deb_pkg;

  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned DEF_CNT_W   = 16;

  // IDLE: synchronised sample agrees with the debounced state.
  // QUAL: sample differs and is being timed.
  typedef enum logic {
    PH_IDLE = 1'b0,
    PH_QUAL = 1'b1
  } phase_e;

  // A length must fit the counter as LEN-1 and be at least one sample.
  function automatic bit len_ok(input int unsigned len, input int unsigned w);
    return (len >= 1) && (64'(len) < (64'd1 << w));
  endfunction

endpackage

// File: rtl/gpio_deb_chan.sv
// One debouncer channel: 2-flop synchroniser, qualification counter,
// debounced state and (with GPIO_DEB_EDGE_EN) registered edge pulses.
module gpio_deb_chan
  import gpio_deb_pkg::*;
#(
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned HIGH_LENGTH = 200,
  parameter int unsigned LOW_LENGTH  = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic st,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam logic [CNT_W-1:0] HIGH_M1 = CNT_W'(HIGH_LENGTH - 1);
  localparam logic [CNT_W-1:0] LOW_M1  = CNT_W'(LOW_LENGTH - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_in;
  logic                   st_q, st_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       len_m1;
  logic                   busy_q;
  phase_e                 phase;

  assign s_in  = sync_q[SYNC_STAGES-1];
  assign phase = (s_in == st_q) ? PH_IDLE : PH_QUAL;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      st_q   <= 1'b0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      busy_q <= (cnt_d != '0);
    end
  end

  // Any sample matching the current state drops the count back to zero,
  // so a qualification only completes on LEN uninterrupted samples.
  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    len_m1 = st_q ? LOW_M1 : HIGH_M1;
    case (phase)
      PH_IDLE: cnt_d = '0;
      PH_QUAL: begin
        if (cnt_q == len_m1) begin
          st_d  = s_in;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: cnt_d = '0;
    endcase
  end

`ifdef GPIO_DEB_EDGE_EN
  logic rise_q, fall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= st_d & ~st_q;
      fall_q <= ~st_d & st_q;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

  assign st   = st_q;
  assign busy = busy_q;

endmodule

// File: rtl/gpio_debounce_mc.sv
// Multi-channel GPIO debouncer / start-strobe generator. Define
// GPIO_DEB_EDGE_EN to build the o_rise/o_fall pulse registers.
module gpio_debounce_mc
  import gpio_deb_pkg::*;
#(
  parameter int unsigned       CH_NUM      = 4,
  parameter int unsigned       CNT_W       = DEF_CNT_W,
  parameter int unsigned       HIGH_LENGTH = 200,
  parameter int unsigned       LOW_LENGTH  = 200,
  parameter logic [CH_NUM-1:0] OUT_INV     = {CH_NUM{1'b1}}
) (
  input  logic              iclk,
  input  logic              irst,
  input  logic [CH_NUM-1:0] ibutton,
  output logic [CH_NUM-1:0] o_start_str,
  output logic [CH_NUM-1:0] o_rise,
  output logic [CH_NUM-1:0] o_fall,
  output logic [CH_NUM-1:0] o_busy
);

  if (CH_NUM < 1 || CH_NUM > 32) begin : g_bad_ch_num
    $error("gpio_debounce_mc: CH_NUM must be 1..32");
  end
  if (!len_ok(HIGH_LENGTH, CNT_W)) begin : g_bad_high
    $error("gpio_debounce_mc: HIGH_LENGTH out of range for CNT_W");
  end
  if (!len_ok(LOW_LENGTH, CNT_W)) begin : g_bad_low
    $error("gpio_debounce_mc: LOW_LENGTH out of range for CNT_W");
  end

  logic [CH_NUM-1:0] st_vec;

  for (genvar i = 0; i < CH_NUM; i++) begin : g_chan
    gpio_deb_chan #(
      .CNT_W      (CNT_W),
      .HIGH_LENGTH(HIGH_LENGTH),
      .LOW_LENGTH (LOW_LENGTH)
    ) u_chan (
      .clk (iclk),
      .rst (irst),
      .pin (ibutton[i]),
      .st  (st_vec[i]),
      .rise(o_rise[i]),
      .fall(o_fall[i]),
      .busy(o_busy[i])
    );
  end

  // st resets to 0, so the strobe comes out of reset equal to OUT_INV.
  assign o_start_str = st_vec ^ OUT_INV;

endmodule

// File: tb/tb_gpio_debounce_mc.sv
// Directed bench for gpio_debounce_mc: a short-length 4-channel instance
// and a 2-channel CNT_W=4 instance at the maximum length of 15.
module tb_gpio_debounce_mc;

`ifdef GPIO_DEB_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn_a;
  logic [3:0] str_a, rise_a, fall_a, busy_a;
  logic [1:0] btn_b;
  logic [1:0] str_b, rise_b, fall_b, busy_b;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  gpio_debounce_mc #(
    .CH_NUM(4), .CNT_W(4), .HIGH_LENGTH(4), .LOW_LENGTH(4)
  ) dut_a (
    .iclk(clk), .irst(rst), .ibutton(btn_a),
    .o_start_str(str_a), .o_rise(rise_a), .o_fall(fall_a), .o_busy(busy_a)
  );

  gpio_debounce_mc #(
    .CH_NUM(2), .CNT_W(4), .HIGH_LENGTH(15), .LOW_LENGTH(1), .OUT_INV(2'b01)
  ) dut_b (
    .iclk(clk), .irst(rst), .ibutton(btn_b),
    .o_start_str(str_b), .o_rise(rise_b), .o_fall(fall_b), .o_busy(busy_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] pulse4(input bit hit, input logic [3:0] v);
    return (hit && EDGE_EN) ? v : 4'h0;
  endfunction

  function automatic logic [1:0] pulse2(input bit hit, input logic [1:0] v);
    return (hit && EDGE_EN) ? v : 2'h0;
  endfunction

  initial begin
    // reset values
    rst = 1'b1; btn_a = 4'h0; btn_b = 2'h0;
    step(); step();
    chk("rst_str_a",  32'(str_a),  32'h0000000F);
    chk("rst_rise_a", 32'(rise_a), 32'h0);
    chk("rst_fall_a", 32'(fall_a), 32'h0);
    chk("rst_busy_a", 32'(busy_a), 32'h0);
    chk("rst_str_b",  32'(str_b),  32'h1);
    chk("rst_busy_b", 32'(busy_b), 32'h0);
    rst = 1'b0;
    step(); step();
    chk("idle_str_a", 32'(str_a), 32'hF);

    // clean press on ch0, HIGH_LENGTH=4: change at edge 5
    btn_a[0] = 1'b1;
    for (int e = 0; e <= 6; e++) begin
      step();
      chk($sformatf("press_str_e%0d", e),  32'(str_a),  32'((e >= 5) ? 4'hE : 4'hF));
      chk($sformatf("press_rise_e%0d", e), 32'(rise_a), 32'(pulse4(e == 5, 4'h1)));
      chk($sformatf("press_busy_e%0d", e), 32'(busy_a), 32'((e >= 2 && e <= 4) ? 4'h1 : 4'h0));
    end

    // bring ch1 to debounced high
    btn_a[1] = 1'b1;
    repeat (7) step();
    chk("ch1_high_str", 32'(str_a), 32'hC);

    // glitch: low 3, high 1, low 7; fall only after 4 uninterrupted lows
    for (int e = 0; e <= 10; e++) begin
      btn_a[1] = (e == 3);
      step();
      chk($sformatf("glitch_str_e%0d", e),  32'(str_a),  32'((e >= 9) ? 4'hE : 4'hC));
      chk($sformatf("glitch_fall_e%0d", e), 32'(fall_a), 32'(pulse4(e == 9, 4'h2)));
      chk($sformatf("glitch_busy_e%0d", e), 32'(busy_a),
          32'((e inside {2, 3, 4, 6, 7, 8}) ? 4'h2 : 4'h0));
    end

    // ch0 falls and ch2 rises on the same edge; ch1/ch3 static
    btn_a = 4'b0100;
    for (int e = 0; e <= 6; e++) begin
      step();
      chk($sformatf("indep_str_e%0d", e),  32'(str_a),  32'((e >= 5) ? 4'hB : 4'hE));
      chk($sformatf("indep_rise_e%0d", e), 32'(rise_a), 32'(pulse4(e == 5, 4'h4)));
      chk($sformatf("indep_fall_e%0d", e), 32'(fall_a), 32'(pulse4(e == 5, 4'h1)));
      chk($sformatf("indep_busy_e%0d", e), 32'(busy_a), 32'((e >= 2 && e <= 4) ? 4'h5 : 4'h0));
    end

    // reset in the middle of a HIGH_LENGTH=15 qualification on dut_b ch0
    btn_b[0] = 1'b1;
    repeat (6) step();
    chk("midq_busy_b", 32'(busy_b), 32'h1);
    chk("midq_str_b",  32'(str_b),  32'h1);
    rst = 1'b1;
    #1;
    chk("async_rst_str_a",  32'(str_a),  32'hF);
    chk("async_rst_busy_a", 32'(busy_a), 32'h0);
    chk("async_rst_str_b",  32'(str_b),  32'h1);
    chk("async_rst_busy_b", 32'(busy_b), 32'h0);
    step();
    rst = 1'b0;
    for (int e = 0; e <= 17; e++) begin
      step();
      chk($sformatf("rq_str_b_e%0d", e),  32'(str_b),  32'((e >= 16) ? 2'b00 : 2'b01));
      chk($sformatf("rq_busy_b_e%0d", e), 32'(busy_b), 32'((e >= 2 && e <= 15) ? 2'b01 : 2'b00));
      chk($sformatf("rq_rise_b_e%0d", e), 32'(rise_b), 32'(pulse2(e == 16, 2'b01)));
      chk($sformatf("rq_str_a_e%0d", e),  32'(str_a),  32'((e >= 5) ? 4'hB : 4'hF));
      chk($sformatf("rq_rise_a_e%0d", e), 32'(rise_a), 32'(pulse4(e == 5, 4'h4)));
    end

    // LOW_LENGTH=1: minimum latency, edge 2, counter never leaves zero
    btn_b[0] = 1'b0;
    for (int e = 0; e <= 3; e++) begin
      step();
      chk($sformatf("min_str_b_e%0d", e),  32'(str_b),  32'((e >= 2) ? 2'b01 : 2'b00));
      chk($sformatf("min_fall_b_e%0d", e), 32'(fall_b), 32'(pulse2(e == 2, 2'b01)));
      chk($sformatf("min_busy_b_e%0d", e), 32'(busy_b), 32'h0);
    end

    // 3-sample pulse on dut_b ch1 (non-inverted) is shorter than 15
    for (int e = 0; e <= 8; e++) begin
      btn_b[1] = (e <= 2);
      step();
      chk($sformatf("short_str_b_e%0d", e),  32'(str_b),  32'h1);
      chk($sformatf("short_rise_b_e%0d", e), 32'(rise_b), 32'h0);
      chk($sformatf("short_busy_b_e%0d", e), 32'(busy_b), 32'((e >= 2 && e <= 4) ? 2'b10 : 2'b00));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
